id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  kill the held instruction (branch/jump redirect).
REQ-005 in_valid / in_ready  input / output  1 / 1  decode-side handshake.
REQ-006 in_pc, in_rs1_data, in_rs2_data, in_imm  input  XLEN each  decoded operands.
REQ-007 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  register indices.
REQ-008 in_alu_op  input  alu_op_e  ALU operation; in_a_sel  input  a_sel_e (RS1/PC); in_b_sel  input  b_sel_e (RS2/IMM); in_reg_write  input  1.
REQ-009 exmem_rd, memwb_rd  input  5; exmem_reg_write, memwb_reg_write  input  1; exmem_result, memwb_result  input  XLEN  forwarding sources.
REQ-010 out_valid / out_ready  output / input  1 / 1  ALU-side handshake.
REQ-011 alu_a, alu_b  output  XLEN; alu_op  output  alu_op_e  drive the ALU a/b/aluCtrl directly.
REQ-012 out_pc, out_store_data  output  XLEN; out_rd_addr  output  5; out_reg_write  output  1.

Function
REQ-013 Block SHALL hold one instruction in a register with a valid bit (out_valid).
REQ-014 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-015 Transfer in: in_valid && in_ready SHALL load all payload and set out_valid at the next edge (latency 1 cycle).
REQ-016 Transfer out: out_valid && out_ready with no load SHALL clear out_valid next edge; simultaneous out and in transfer SHALL replace payload, out_valid stays 1 (full throughput, no bubble).
REQ-017 Stall: out_valid && !out_ready SHALL hold alu_op, out_rd_addr, out_reg_write, out_pc, selects stable.
REQ-018 flush SHALL clear out_valid next edge, overriding any same-cycle load; in_ready unaffected by flush.
REQ-019 Operands: alu_a = (a_sel==PC) ? pc : rs1_eff; alu_b = (b_sel==IMM) ? imm : rs2_eff; out_store_data = rs2_eff; all combinational from held state.
REQ-020 rs*_eff SHALL be held rs*_data unless forwarding applies (REQ-025).
REQ-021 All outputs SHALL reflect the held register even when out_valid=0; consumers SHALL qualify with out_valid.
REQ-022 in_valid=0 with in_ready=1 SHALL NOT alter held payload.

Reset
REQ-023 rst_n low SHALL immediately clear out_valid and all payload to 0, alu_op to ENUM_ALU_ADD, selects to RS1/RS2, out_reg_write to 0.
REQ-024 Deassertion mid-stream: first load accepted on the first edge with rst_n high and in_valid high.

Configuration
REQ-025 Macro ID_EX_FWD_EN defined: rs1_eff = exmem_result if exmem_reg_write && exmem_rd==rs1_addr && rs1_addr!=0; else memwb_result if memwb_reg_write && memwb_rd==rs1_addr && rs1_addr!=0; else held data; rs2 identically. EX/MEM SHALL win over MEM/WB.
REQ-026 With ID_EX_FWD_EN, while stalled (out_valid && !out_ready) the held rs1/rs2 data SHALL be overwritten each edge with rs*_eff, so a producer retiring during the stall is not lost.
REQ-027 Without ID_EX_FWD_EN: forwarding ports SHALL remain present and be ignored; rs*_eff = held data.

Structure
REQ-028 Package types SHALL hold alu_op_e (existing), a_sel_e, b_sel_e, fwd_sel_e (NONE/EXMEM/MEMWB).
REQ-029 Forwarding selection SHALL live in sub-module fwd_unit (combinational, one per operand instance), compiled only under ID_EX_FWD_EN.

Verification
REQ-030 Load rs1=25, rs2=10, op ADD, a=RS1, b=RS2, out_ready=1 -> next cycle out_valid=1, alu_a=25, alu_b=10; ALU result 35.
REQ-031 Held op, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged, new op accepted the cycle out_ready rises, no bubble.
REQ-032 flush and in_valid same cycle -> out_valid=0 next cycle; b=IMM with imm=0xFFFFF800 then shows alu_b=0xFFFFF800 on a later load.
REQ-033 FWD_EN: rs1_addr=5, exmem_rd=5 (result 0x11), memwb_rd=5 (0x22) -> alu_a=0x11; exmem_reg_write=0 -> 0x22; rs1_addr=0 -> held data.
REQ-034 FWD_EN: stalled, exmem forwards 0x33 for one cycle then drops -> alu_a stays 0x33 after release.
REQ-035 rst_n pulsed low while out_valid=1 -> out_valid=0 and alu_op=ENUM_ALU_ADD without a clock edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg -- shared types for the ID/EX pipeline register.
//   alu_op_e  : ALU operation encoding driven to the ALU aluCtrl input
//   a_sel_e   : ALU operand A source (RS1 or PC)
//   b_sel_e   : ALU operand B source (RS2 or immediate)
//   fwd_sel_e : operand forwarding source (none, EX/MEM, MEM/WB)
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ENUM_ALU_ADD  = 4'd0,
        ENUM_ALU_SUB  = 4'd1,
        ENUM_ALU_AND  = 4'd2,
        ENUM_ALU_OR   = 4'd3,
        ENUM_ALU_XOR  = 4'd4,
        ENUM_ALU_SLL  = 4'd5,
        ENUM_ALU_SRL  = 4'd6,
        ENUM_ALU_SRA  = 4'd7,
        ENUM_ALU_SLT  = 4'd8,
        ENUM_ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic {
        A_SEL_RS1 = 1'b0,
        A_SEL_PC  = 1'b1
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // x0 is hard-wired zero and must never be forwarded.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit -- combinational operand forwarding selector, one per source operand.
// Only built when the ID_EX_FWD_EN macro is defined.
// Ports:
//   rs_addr, rs_data           : operand register index and the value held in ID/EX
//   exmem_rd/_reg_write/_result: producer currently in EX/MEM
//   memwb_rd/_reg_write/_result: producer currently in MEM/WB
//   fwd_sel                    : chosen source
//   rs_eff                     : effective operand value
`ifdef ID_EX_FWD_EN
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output fwd_sel_e        fwd_sel,
    output logic [XLEN-1:0] rs_eff
);

    // EX/MEM is the younger producer, so it is checked first.
    always_comb begin
        fwd_sel = FWD_NONE;
        if ((rs_addr != REG_ZERO) && exmem_reg_write && (exmem_rd == rs_addr)) begin
            fwd_sel = FWD_EXMEM;
        end else if ((rs_addr != REG_ZERO) && memwb_reg_write && (memwb_rd == rs_addr)) begin
            fwd_sel = FWD_MEMWB;
        end else begin
            fwd_sel = FWD_NONE;
        end
    end

    // Operand mux driven by the selection above.
    always_comb begin
        rs_eff = rs_data;
        case (fwd_sel)
            FWD_EXMEM: rs_eff = exmem_result;
            FWD_MEMWB: rs_eff = memwb_result;
            FWD_NONE:  rs_eff = rs_data;
            default:   rs_eff = rs_data;
        endcase
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with valid/ready handshake.
// Holds one decoded instruction and drives the ALU operands directly from the
// held state. Optional operand forwarding is enabled with the ID_EX_FWD_EN macro;
// without it the forwarding ports are present but ignored.
// Ports:
//   clk, rst_n (async active-low), flush (kills the held instruction)
//   in_valid/in_ready + in_* payload     : decode side
//   exmem_*/memwb_*                      : forwarding sources
//   out_valid/out_ready                  : ALU side
//   alu_a, alu_b, alu_op                 : ALU inputs
//   out_pc, out_store_data, out_rd_addr, out_reg_write : carried-forward payload
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  alu_op_e         in_alu_op,
    input  a_sel_e          in_a_sel,
    input  b_sel_e          in_b_sel,
    input  logic            in_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_op_e         alu_op,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_write
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d;
    logic [4:0]      rs2_addr_q, rs2_addr_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    alu_op_e         alu_op_q, alu_op_d;
    a_sel_e          a_sel_q, a_sel_d;
    b_sel_e          b_sel_q, b_sel_d;
    logic            reg_write_q, reg_write_d;

    logic            load_s;
    logic            stall_s;
    logic [XLEN-1:0] rs1_eff_s;
    logic [XLEN-1:0] rs2_eff_s;

`ifdef ID_EX_FWD_EN
    fwd_sel_e rs1_fwd_sel_s;
    fwd_sel_e rs2_fwd_sel_s;
    logic     unused_fwd_s;

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr(rs1_addr_q), .rs_data(rs1_data_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .fwd_sel(rs1_fwd_sel_s), .rs_eff(rs1_eff_s)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr(rs2_addr_q), .rs_data(rs2_data_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .fwd_sel(rs2_fwd_sel_s), .rs_eff(rs2_eff_s)
    );

    // The selection codes are informational only.
    assign unused_fwd_s = ^{rs1_fwd_sel_s, rs2_fwd_sel_s};
`else
    logic unused_fwd_s;

    assign rs1_eff_s = rs1_data_q;
    assign rs2_eff_s = rs2_data_q;
    // Forwarding inputs and operand indices have no consumer in this build.
    assign unused_fwd_s = ^{exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write,
                            exmem_result, memwb_result, rs1_addr_q, rs2_addr_q};
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign load_s   = in_valid && in_ready;
    assign stall_s  = out_valid_q && !out_ready;

    // Next-state for valid bit and held payload.
    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_op_d    = alu_op_q;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        reg_write_d = reg_write_q;

        // Flush wins over a same-cycle load; a simultaneous drain and load keeps valid high.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_s) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (load_s && !flush) begin
            pc_d        = in_pc;
            rs1_data_d  = in_rs1_data;
            rs2_data_d  = in_rs2_data;
            imm_d       = in_imm;
            rs1_addr_d  = in_rs1_addr;
            rs2_addr_d  = in_rs2_addr;
            rd_addr_d   = in_rd_addr;
            alu_op_d    = in_alu_op;
            a_sel_d     = in_a_sel;
            b_sel_d     = in_b_sel;
            reg_write_d = in_reg_write;
        end else if (stall_s) begin
            // Capture forwarded values while stalled so a producer retiring
            // from the pipeline during the stall is not lost.
            rs1_data_d = rs1_eff_s;
            rs2_data_d = rs2_eff_s;
        end else begin
            rs1_data_d = rs1_data_q;
            rs2_data_d = rs2_data_q;
        end
    end

    // Pipeline register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rd_addr_q   <= 5'd0;
            alu_op_q    <= ENUM_ALU_ADD;
            a_sel_q     <= A_SEL_RS1;
            b_sel_q     <= B_SEL_RS2;
            reg_write_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_op_q    <= alu_op_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_op         = alu_op_q;
    assign alu_a          = (a_sel_q == A_SEL_PC)  ? pc_q  : rs1_eff_s;
    assign alu_b          = (b_sel_q == B_SEL_IMM) ? imm_q : rs2_eff_s;
    assign out_store_data = rs2_eff_s;
    assign out_pc         = pc_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_reg_write  = reg_write_q;

endmodule
